// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the execute->writeback memory slot.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Load funct3 encodings.
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

  // Store funct3 encodings.
  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } st_funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for stores, misalignment detection, and load extraction.
module lsu_align
  import rv32_pkg::*;
(
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rs2,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_rs2;
    case (i_funct3)
      F3_SB: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_rs2[7:0]}};
      end
      F3_SH: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_rs2[15:0]}};
      end
      F3_SW: begin
        o_be    = 4'b1111;
        o_wdata = i_rs2;
      end
      default: ;
    endcase
  end

  // Halfwords need an even offset, words a zero offset.
  always_comb begin
    o_misaligned = 1'b0;
    case (i_funct3)
      3'b001:  o_misaligned = i_off[0];
      3'b101:  o_misaligned = i_is_load & i_off[0];
      3'b010:  o_misaligned = |i_off;
      default: o_misaligned = 1'b0;
    endcase
  end

  // Select the addressed byte/half from the returned word and extend it.
  always_comb begin
    w_byte    = i_rdata[{i_ld_off, 3'b000} +: 8];
    w_half    = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_ld_data = i_rdata;
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_ld_data = i_rdata;
      F3_LBU:  o_ld_data = {24'h000000, w_byte};
      F3_LHU:  o_ld_data = {16'h0000, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_slot.sv
// Memory-capable execute->writeback slot: data-memory access FSM plus writeback registers.
module mem_slot
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [31:0]     instr,
  input  logic            reg_file_en_i,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic [XLEN-1:0] pc_excte,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            misalign_o,
  output logic            timeout_o,
  output logic            reg_file_en_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_addr;
  logic [3:0]       r_be;
  logic [XLEN-1:0]  r_wdata;
  logic [31:0]      r_cap_instr;
  logic [XLEN-1:0]  r_cap_pc;
  logic             r_cap_en;
  logic             r_timeout;
  logic             r_reg_file_en;
  logic [XLEN-1:0]  r_wb_data;
  logic [XLEN-1:0]  r_pc;
  logic [31:0]      r_instr;

  logic             w_is_load;
  logic             w_is_store;
  logic             w_is_mem;
  logic             w_misaligned;
  logic [3:0]       w_be;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_ld_data;
  logic             w_stall;

  assign w_is_load  = (instr[6:0] == OP_LOAD);
  assign w_is_store = (instr[6:0] == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;

  lsu_align u_lsu_align (
    .i_is_load    (w_is_load),
    .i_funct3     (instr[14:12]),
    .i_off        (alu_out_i[1:0]),
    .i_rs2        (rs2_data_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .i_ld_funct3  (r_funct3),
    .i_ld_off     (r_addr[1:0]),
    .i_rdata      (dmem_rdata_i),
    .o_ld_data    (w_ld_data)
  );

  // Freeze upstream while a memory access is outstanding.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_is_mem & ~w_misaligned;
      REQ:     w_stall = ~(dmem_gnt_i & (r_is_store | dmem_rvalid_i));
      WAIT:    w_stall = ~dmem_rvalid_i;
      default: w_stall = 1'b0;
    endcase
  end

  // FSM, access capture and writeback registers; every stall cycle emits a bubble.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_is_store    <= 1'b0;
      r_funct3      <= 3'b000;
      r_addr        <= '0;
      r_be          <= 4'b0000;
      r_wdata       <= '0;
      r_cap_instr   <= 32'h0;
      r_cap_pc      <= '0;
      r_cap_en      <= 1'b0;
      r_timeout     <= 1'b0;
      r_reg_file_en <= 1'b0;
      r_wb_data     <= '0;
      r_pc          <= '0;
      r_instr       <= 32'h0;
    end else begin
      r_timeout     <= 1'b0;
      r_reg_file_en <= 1'b0;
      r_wb_data     <= '0;
      r_pc          <= '0;
      r_instr       <= 32'h0;
      case (r_state)
        IDLE: begin
          if (!w_is_mem) begin
            r_instr       <= instr;
            r_pc          <= pc_excte;
            r_reg_file_en <= reg_file_en_i;
            r_wb_data     <= alu_out_i;
          end else if (w_misaligned) begin
            r_instr <= instr;
            r_pc    <= pc_excte;
          end else begin
            r_is_store  <= w_is_store;
            r_funct3    <= instr[14:12];
            r_addr      <= alu_out_i;
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_cap_instr <= instr;
            r_cap_pc    <= pc_excte;
            r_cap_en    <= reg_file_en_i;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            if (r_is_store) begin
              r_instr <= r_cap_instr;
              r_pc    <= r_cap_pc;
              r_state <= IDLE;
            end else if (dmem_rvalid_i) begin
              r_instr       <= r_cap_instr;
              r_pc          <= r_cap_pc;
              r_reg_file_en <= r_cap_en;
              r_wb_data     <= w_ld_data;
              r_state       <= IDLE;
            end else begin
              r_wait_cnt <= '0;
              r_state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            r_instr       <= r_cap_instr;
            r_pc          <= r_cap_pc;
            r_reg_file_en <= r_cap_en;
            r_wb_data     <= w_ld_data;
            r_state       <= IDLE;
          end else if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req_o    = (r_state == REQ);
  assign dmem_we_o     = (r_state == REQ) & r_is_store;
  assign dmem_addr_o   = {r_addr[XLEN-1:2], 2'b00};
  assign dmem_be_o     = r_be;
  assign dmem_wdata_o  = r_wdata;
  assign stall_o       = w_stall;
  assign misalign_o    = (r_state == IDLE) & w_is_mem & w_misaligned;
  assign timeout_o     = r_timeout;
  assign reg_file_en_o = r_reg_file_en;
  assign wb_data_o     = r_wb_data;
  assign pc_o          = r_pc;
  assign instr_o       = r_instr;

endmodule

// File: doc/mem_slot.md
Name: mem_slot

Overview:
- Memory-capable slot of the dual-issue execute→writeback boundary; counterpart of the pass-through register on the non-memory slot.
- Takes execute results, performs the data-memory access over a req/gnt/rvalid interface, aligns and extends load data, and hands the result to writeback.
- Non-memory instructions pass with 1-cycle latency.
- Memory instructions raise stall_o, which freezes both slots so in-order retirement is preserved.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- MAX_WAIT, 255, WAIT cycles before timeout_o pulses and the FSM aborts to IDLE.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  synchronous active-low reset
- instr  in  32  instruction from execute; held stable while stall_o=1
- reg_file_en_i  in  1  writeback enable from execute
- alu_out_i  in  32  ALU result, or effective address for loads/stores
- pc_excte  in  32  PC from execute
- rs2_data_i  in  32  store data from execute
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load word
- stall_o  out  1  freeze execute and both slots (combinational)
- misalign_o  out  1  1-cycle pulse on misaligned access
- timeout_o  out  1  1-cycle pulse on WAIT timeout
- reg_file_en_o  out  1  to writeback
- wb_data_o  out  32  to writeback: ALU result or extended load data
- pc_o  out  32  to writeback
- instr_o  out  32  to writeback

Behaviour:
- Reset (rstn_i=0 at a clock edge): state=IDLE; all outputs 0; wait counter 0.
- Reset mid-access drops dmem_req_o the next cycle; any later gnt/rvalid is ignored in IDLE.
- Decode: load = opcode 0000011; store = opcode 0100011; funct3 = instr[14:12]; offset = alu_out_i[1:0].
- Non-memory instruction in IDLE:
  - Next edge registers instr, pc, reg_file_en_i and alu_out_i (onto wb_data_o).
  - stall_o=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE with a memory op at input:
  - Aligned: stall_o=1. Edge captures instr, pc, addr, be, wdata and funct3; state→REQ.
  - Outputs during any stall cycle are a bubble: instr_o=0, reg_file_en_o=0, wb_data_o=0, pc_o=0.
  - Misaligned (LH/LHU/SH with offset odd; LW/SW with offset≠0): no request, stall_o=0, misalign_o=1 this cycle.
  - Misaligned next edge: instr_o/pc_o pass through, reg_file_en_o=0, wb_data_o=0.
- REQ:
  - dmem_req_o=1 with address, be, we and wdata stable until dmem_gnt_i.
  - Store with gnt: stall_o=0. Edge outputs instr_o/pc_o, reg_file_en_o=0; state→IDLE.
  - Load with gnt and rvalid in the same cycle: completes as in WAIT (zero-latency memory).
  - Load with gnt only: state→WAIT, stall_o stays 1.
  - rvalid without gnt in REQ is ignored.
- WAIT:
  - dmem_req_o=0; stall_o = !dmem_rvalid_i.
  - On rvalid the edge registers the extended data to wb_data_o, reg_file_en_o = captured enable, plus instr_o and pc_o; state→IDLE.
  - Upstream advances on the same edge, so a back-to-back memory op is seen in IDLE the next cycle.
  - Counter reaches MAX_WAIT: timeout_o pulse, bubble output, state→IDLE.
- Load extraction: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Unknown funct3: zero-extended word.
- Store lanes:
  - SB: be = 0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<off, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- stall_o is never asserted in IDLE for non-memory ops.

Decomposition:
- rv32_pkg holds:
  - opcode constants OP_LOAD and OP_STORE;
  - funct3 enum (F3_LB/LH/LW/LBU/LHU, F3_SB/SH/SW);
  - mem_state_t {IDLE, REQ, WAIT}.
- Sub-module lsu_align (combinational): computes be, wdata and misaligned from funct3/offset/rs2, and extended load data from funct3/offset/rdata.
- mem_slot holds the FSM, capture registers, wait counter and writeback registers.

Test Plan:
- ADD instr, alu_out_i=0x1234, reg_file_en_i=1 → next cycle wb_data_o=0x1234, reg_file_en_o=1, stall_o never 1.
- LB at addr 0x1003, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x80FF_0000 → stall_o high throughout, dmem_addr_o=0x1000; after rvalid wb_data_o=0xFFFF_FF80, reg_file_en_o=1.
- SH at addr 0x2002, rs2=0xABCD → dmem_be_o=1100, dmem_wdata_o=0xABCD_ABCD, dmem_we_o=1; completes on gnt with reg_file_en_o=0.
- LW at addr 0x3001 → misalign_o pulse, dmem_req_o stays 0, stall_o 0, next cycle reg_file_en_o=0.
- LHU at 0x4002 with gnt and rvalid same cycle, rdata=0xF00D_1234 → single stall cycle, wb_data_o=0x0000_F00D.
- rstn_i=0 while in WAIT, then stray rvalid → outputs 0, state IDLE, rvalid ignored; no rvalid with MAX_WAIT=4 → timeout_o after 4 WAIT cycles.
